// File: rtl/cd_image_reader.sv
// cd_image_reader: answers SCSI TEST UNIT READY / READ6 / READ10 command blocks
// from the bridge. It fetches 2048-byte sectors from a disc image held in
// 16-bit external memory and streams them out as a paced byte stream. When the
// command completes it presents the SCSI status byte.
//
// Image port handshake (valid/ready): IMG_RD is the request. It is held, with
// IMG_A frozen, until a CE-cycle in which IMG_READYn is low. That cycle is the
// transfer: IMG_DO is sampled in it. IMG_RD drops on the following CE-cycle.
// Only CE=1 cycles count for anything.
module cd_image_reader #(
    parameter int unsigned IMG_BASE    = 0,
    parameter int unsigned IMG_SECTORS = 4096,
    parameter int unsigned BYTE_GAP    = 8,
    parameter int unsigned AW          = 22
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          CE,
    input  logic [95:0]   COMMAND,
    input  logic          COMM_SEND,
    input  logic          STAT_GET,
    output logic [7:0]    STATUS,
    output logic [7:0]    CD_DATA,
    output logic          CD_WR,
    output logic          CD_DATA_END,
    output logic [AW-1:0] IMG_A,
    output logic          IMG_RD,
    input  logic [15:0]   IMG_DO,
    input  logic          IMG_READYn,
    output logic          BUSY,
    output logic [2:0]    dbg_state_o
);

    localparam int GW = $clog2(BYTE_GAP + 1);
    localparam logic [GW-1:0] GAP_FULL   = GW'(BYTE_GAP);
    localparam logic [32:0]   SECTORS_33 = 33'(IMG_SECTORS);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_FETCH, S_EMIT_LO, S_EMIT_HI, S_END, S_STATUS_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [95:0]     cmd_q, cmd_d;
    logic [31:0]     lba_q, lba_d;
    logic [16:0]     count_q, count_d;   // sectors left, including the current one
    logic [9:0]      widx_q, widx_d;
    logic [15:0]     word_q, word_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      status_q, status_d;
    logic [7:0]      data_q, data_d;
    logic            wr_q, wr_d;
    logic            end_q, end_d;
    logic            rd_q, rd_d;
    logic            busy_q, busy_d;
    logic [AW-1:0]   addr_q, addr_d;

    logic [7:0]      opcode;
    logic            is_read;
    logic [31:0]     dec_lba;
    logic [16:0]     dec_cnt;
    logic            out_of_range;

    // Word address of a sector word. The image may wrap within the AW-bit space.
    function automatic logic [AW-1:0] img_addr(input logic [31:0] lba, input logic [9:0] idx);
        logic [41:0] full;
        full = 42'(IMG_BASE) + {lba, 10'b0} + {32'b0, idx};
        return full[AW-1:0];
    endfunction

    // Decode the latched CDB into LBA and sector count, plus a 33-bit range check.
    always_comb begin
        opcode  = cmd_q[7:0];
        is_read = 1'b0;
        dec_lba = '0;
        dec_cnt = '0;
        if (opcode == 8'h08) begin
            is_read = 1'b1;
            dec_lba = {11'd0, cmd_q[12:8], cmd_q[23:16], cmd_q[31:24]};
            dec_cnt = (cmd_q[39:32] == 8'd0) ? 17'd256 : {9'd0, cmd_q[39:32]};
        end else if (opcode == 8'h28) begin
            is_read = 1'b1;
            dec_lba = {cmd_q[23:16], cmd_q[31:24], cmd_q[39:32], cmd_q[47:40]};
            dec_cnt = {1'b0, cmd_q[63:56], cmd_q[71:64]};
        end
        out_of_range = ({1'b0, dec_lba} + {16'd0, dec_cnt}) > SECTORS_33;
    end

    // Next-state and registered-output logic for the command FSM.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        lba_d    = lba_q;
        count_d  = count_q;
        widx_d   = widx_q;
        word_d   = word_q;
        status_d = status_q;
        data_d   = data_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wr_d     = 1'b0;
        end_d    = 1'b0;
        gap_d    = (gap_q < GAP_FULL) ? gap_q + GW'(1) : gap_q;

        case (state_q)
            S_IDLE: begin
                if (COMM_SEND) begin
                    cmd_d   = COMMAND;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!is_read) begin
                    status_d = (opcode == 8'h00) ? 8'h00 : 8'h02;
                    state_d  = S_END;
                end else if (out_of_range) begin
                    status_d = 8'h02;
                    state_d  = S_END;
                end else if (dec_cnt == 17'd0) begin
                    status_d = 8'h00;
                    state_d  = S_END;
                end else begin
                    status_d = 8'h00;
                    lba_d    = dec_lba;
                    count_d  = dec_cnt;
                    widx_d   = 10'd0;
                    gap_d    = GAP_FULL;   // first byte goes out without delay
                    rd_d     = 1'b1;
                    addr_d   = img_addr(dec_lba, 10'd0);
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!IMG_READYn) begin
                    word_d  = IMG_DO;
                    rd_d    = 1'b0;
                    state_d = S_EMIT_LO;
                end
            end
            S_EMIT_LO: begin
                if (gap_q >= GAP_FULL) begin
                    wr_d    = 1'b1;
                    data_d  = word_q[7:0];
                    gap_d   = GW'(1);   // the strobe cycle is the first counted
                    state_d = S_EMIT_HI;
                end
            end
            S_EMIT_HI: begin
                if (gap_q >= GAP_FULL) begin
                    wr_d   = 1'b1;
                    data_d = word_q[15:8];
                    gap_d  = GW'(1);
                    if (widx_q == 10'd1023 && count_q == 17'd1) begin
                        status_d = 8'h00;
                        state_d  = S_END;
                    end else if (widx_q == 10'd1023) begin
                        widx_d  = 10'd0;
                        lba_d   = lba_q + 32'd1;
                        count_d = count_q - 17'd1;
                        rd_d    = 1'b1;
                        addr_d  = img_addr(lba_q + 32'd1, 10'd0);
                        state_d = S_FETCH;
                    end else begin
                        widx_d  = widx_q + 10'd1;
                        rd_d    = 1'b1;
                        addr_d  = img_addr(lba_q, widx_q + 10'd1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_END: begin
                end_d   = 1'b1;
                state_d = S_STATUS_WAIT;
            end
            S_STATUS_WAIT: begin
                if (STAT_GET) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset wins over CE.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            lba_q    <= '0;
            count_q  <= '0;
            widx_q   <= '0;
            word_q   <= '0;
            gap_q    <= '0;
            status_q <= 8'h00;
            data_q   <= 8'h00;
            wr_q     <= 1'b0;
            end_q    <= 1'b0;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
        end else if (CE) begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            lba_q    <= lba_d;
            count_q  <= count_d;
            widx_q   <= widx_d;
            word_q   <= word_d;
            gap_q    <= gap_d;
            status_q <= status_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            end_q    <= end_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
        end
    end

    assign STATUS      = status_q;
    assign CD_DATA     = data_q;
    assign CD_WR       = wr_q;
    assign CD_DATA_END = end_q;
    assign IMG_A       = addr_q;
    assign IMG_RD      = rd_q;
    assign BUSY        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cd_image_reader.sv
// Bench for cd_image_reader: a memory responder with random latency, a bus
// monitor, and a reference model that derives status, byte stream and image
// addresses directly from the command block.
module tb_cd_image_reader;

    localparam int unsigned IMG_BASE    = 256;
    localparam int unsigned IMG_SECTORS = 4096;
    localparam int unsigned BYTE_GAP    = 8;
    localparam int unsigned AW          = 22;

    logic          clk = 1'b0;
    logic          res, ce, comm_send, stat_get, img_readyn;
    logic [95:0]   command;
    logic [15:0]   img_do;
    logic [7:0]    status, cd_data;
    logic          cd_wr, cd_end, img_rd, busy;
    logic [AW-1:0] img_a;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    // clock / reset block
    always #5 clk = ~clk;

    cd_image_reader #(.IMG_BASE(IMG_BASE), .IMG_SECTORS(IMG_SECTORS),
                      .BYTE_GAP(BYTE_GAP), .AW(AW)) dut (
        .CLK(clk), .RES(res), .CE(ce), .COMMAND(command), .COMM_SEND(comm_send),
        .STAT_GET(stat_get), .STATUS(status), .CD_DATA(cd_data), .CD_WR(cd_wr),
        .CD_DATA_END(cd_end), .IMG_A(img_a), .IMG_RD(img_rd), .IMG_DO(img_do),
        .IMG_READYn(img_readyn), .BUSY(busy), .dbg_state_o(dbg_state)
    );

    // scoreboard state
    logic [7:0]    exp_q[$];
    logic [7:0]    got_q[$];
    logic [AW-1:0] addr_q[$];
    int end_cnt, bytes_at_end, min_gap, last_wr_edge, unstable_cnt;
    int ce_edges = 0;
    int ce_mode = 0;     // 0: CE=1, 1: random CE, 2: CE=0
    int stall_next = 0;
    logic wr_prev = 1'b0, end_prev = 1'b0, rd_prev = 1'b0;
    logic [AW-1:0] a_prev = '0;

    // Image contents: word at IMG_BASE is 0x3412, everything else a hash of the address.
    function automatic logic [15:0] mem_word(input longint unsigned a);
        longint unsigned h;
        if (a == longint'(IMG_BASE)) return 16'h3412;
        h = a * 64'd2654435761 + 64'd12345;
        return h[31:16];
    endfunction

    function automatic logic [95:0] cdb10(input logic [31:0] lba, input logic [15:0] cnt);
        logic [95:0] c;
        c = '0;
        c[7:0]   = 8'h28;
        c[23:16] = lba[31:24];
        c[31:24] = lba[23:16];
        c[39:32] = lba[15:8];
        c[47:40] = lba[7:0];
        c[63:56] = cnt[15:8];
        c[71:64] = cnt[7:0];
        return c;
    endfunction

    function automatic logic [95:0] cdb6(input logic [7:0] b1, input logic [7:0] b2,
                                         input logic [7:0] b3, input logic [7:0] b4);
        logic [95:0] c;
        c = '0;
        c[7:0]   = 8'h08;
        c[15:8]  = b1;
        c[23:16] = b2;
        c[31:24] = b3;
        c[39:32] = b4;
        return c;
    endfunction

    // Reference model: status, first LBA and number of sectors delivered.
    function automatic logic [7:0] model_status(input logic [95:0] c,
                                                output longint unsigned lba,
                                                output longint unsigned cnt);
        logic [7:0] b [12];
        logic [7:0] st;
        for (int i = 0; i < 12; i++) b[i] = c[8*i +: 8];
        lba = 0;
        cnt = 0;
        st  = 8'h00;
        if (b[0] == 8'h08) begin
            lba = longint'(b[1] % 32) * 65536 + longint'(b[2]) * 256 + longint'(b[3]);
            cnt = (b[4] == 8'd0) ? 256 : longint'(b[4]);
        end else if (b[0] == 8'h28) begin
            lba = longint'(b[2]) * 16777216 + longint'(b[3]) * 65536
                + longint'(b[4]) * 256 + longint'(b[5]);
            cnt = longint'(b[7]) * 256 + longint'(b[8]);
        end else if (b[0] != 8'h00) begin
            st = 8'h02;
        end
        if ((b[0] == 8'h08 || b[0] == 8'h28) && lba + cnt > longint'(IMG_SECTORS)) begin
            st  = 8'h02;
            cnt = 0;
        end
        return st;
    endfunction

    function automatic logic [AW-1:0] word_addr(input longint unsigned lba, input longint unsigned i);
        longint unsigned full;
        logic [AW-1:0] a;
        full = longint'(IMG_BASE) + lba * 1024 + i;
        a = full[AW-1:0];
        return a;
    endfunction

    task automatic fill_expected(input longint unsigned lba, input longint unsigned cnt);
        logic [15:0] m;
        exp_q.delete();
        for (longint unsigned i = 0; i < cnt * 1024; i++) begin
            m = mem_word(longint'(word_addr(lba, i)));
            exp_q.push_back(m[7:0]);
            exp_q.push_back(m[15:8]);
        end
    endtask

    function automatic int stream_mismatches(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) bad++;
        return bad;
    endfunction

    function automatic int addr_mismatches(input longint unsigned lba);
        int bad = 0;
        for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] !== word_addr(lba, longint'(i))) bad++;
        return bad;
    endfunction

    // CE driver, changed just after the falling edge
    initial begin
        ce = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            case (ce_mode)
                0:       ce = 1'b1;
                1:       ce = ($urandom_range(0, 3) != 0);
                default: ce = 1'b0;
            endcase
        end
    end

    always @(posedge clk) if (ce) ce_edges++;

    // Image memory responder with random (or forced) latency
    initial begin
        int wait_cnt, lat;
        bit active;
        active = 0; wait_cnt = 0; lat = 0;
        img_readyn = 1'b1;
        img_do = '0;
        forever begin
            @(negedge clk);
            if (img_rd) begin
                if (!active) begin
                    active = 1;
                    wait_cnt = 0;
                    lat = (stall_next != 0) ? stall_next : int'($urandom_range(0, 2));
                    stall_next = 0;
                end
                if (wait_cnt >= lat) begin
                    img_readyn = 1'b0;
                    img_do = mem_word(longint'(img_a));
                end else begin
                    img_readyn = 1'b1;
                    img_do = 16'($urandom);
                end
                wait_cnt++;
            end else begin
                active = 0;
                img_readyn = 1'b1;
            end
        end
    end

    // Bus monitor
    always @(negedge clk) begin
        if (cd_wr && !wr_prev) begin
            if (got_q.size() > 0 && (ce_edges - last_wr_edge) < min_gap)
                min_gap = ce_edges - last_wr_edge;
            last_wr_edge = ce_edges;
            got_q.push_back(cd_data);
        end
        if (cd_end && !end_prev) begin
            end_cnt++;
            bytes_at_end = got_q.size();
        end
        if (img_rd && !rd_prev) addr_q.push_back(img_a);
        if (img_rd && rd_prev && img_a !== a_prev) unstable_cnt++;
        wr_prev  = cd_wr;
        end_prev = cd_end;
        rd_prev  = img_rd;
        a_prev   = img_a;
    end

    // driver tasks
    task automatic clear_obs();
        got_q.delete();
        addr_q.delete();
        end_cnt = 0;
        bytes_at_end = -1;
        min_gap = 1 << 30;
        unstable_cnt = 0;
    endtask

    task automatic send_cmd(input logic [95:0] c);
        @(negedge clk);
        command = c;
        comm_send = 1'b1;
        @(posedge clk);
        while (!ce) @(posedge clk);
        @(negedge clk);
        comm_send = 1'b0;
    endtask

    task automatic get_status();
        @(negedge clk);
        stat_get = 1'b1;
        @(posedge clk);
        while (!ce) @(posedge clk);
        @(negedge clk);
        stat_get = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_end(input int budget, output bit timed_out);
        int n = 0;
        while (end_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        timed_out = (end_cnt == 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_bytes(input int count, input int budget, output bit timed_out);
        int n = 0;
        while (got_q.size() < count && n < budget) begin
            @(negedge clk);
            n++;
        end
        timed_out = (got_q.size() < count);
    endtask

    // tests
    task automatic test_reset();
        res = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        res = 1'b0;
        checks++;
        if ({status, cd_data} !== 16'h0000) begin
            errors++; $display("FAIL reset_status_data: got %h expected 0000", {status, cd_data});
        end
        checks++;
        if ({cd_wr, cd_end, img_rd, busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0000", {cd_wr, cd_end, img_rd, busy});
        end
        checks++;
        if (img_a !== '0) begin
            errors++; $display("FAIL reset_img_a: got %h expected 0", img_a);
        end
    endtask

    task automatic test_read10_single();
        logic [95:0] c;
        longint unsigned lba, cnt;
        logic [7:0] st;
        bit to;
        int n;
        clear_obs();
        c = cdb10(32'd0, 16'd1);
        st = model_status(c, lba, cnt);
        fill_expected(lba, cnt);
        stall_next = 60;
        send_cmd(c);
        n = 0;
        while (addr_q.size() == 0 && n < 20) begin @(negedge clk); n++; end
        repeat (50) @(negedge clk);
        checks++;
        if ({img_rd, img_a} !== {1'b1, word_addr(0, 0)}) begin
            errors++; $display("FAIL stall_request: got rd=%b a=%h expected rd=1 a=%h", img_rd, img_a, word_addr(0, 0));
        end
        checks++;
        if (got_q.size() != 0) begin
            errors++; $display("FAIL stall_no_bytes: got %0d bytes expected 0", got_q.size());
        end
        wait_end(40000, to);
        checks++;
        if (to || got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL r10_byte_count: got %0d expected %0d (timeout=%0d)", got_q.size(), exp_q.size(), to);
        end
        checks++;
        if (got_q.size() < 2 || {got_q[1], got_q[0]} !== 16'h3412) begin
            errors++; $display("FAIL r10_first_bytes: got size %0d expected 12,34", got_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        checks++;
        if (stream_mismatches(n) != 0) begin
            errors++; $display("FAIL r10_stream: got %0d bad bytes expected 0", stream_mismatches(n));
        end
        checks++;
        if (min_gap < int'(BYTE_GAP)) begin
            errors++; $display("FAIL r10_byte_gap: got %0d expected >= %0d", min_gap, BYTE_GAP);
        end
        checks++;
        if (end_cnt != 1 || bytes_at_end != exp_q.size()) begin
            errors++; $display("FAIL r10_end_pulse: got %0d pulses at byte %0d expected 1 at %0d", end_cnt, bytes_at_end, exp_q.size());
        end
        checks++;
        if (addr_q.size() != 1024 || addr_mismatches(lba) != 0 || unstable_cnt != 0) begin
            errors++; $display("FAIL r10_addresses: got %0d reqs, %0d bad, %0d unstable expected 1024,0,0", addr_q.size(), addr_mismatches(lba), unstable_cnt);
        end
        checks++;
        if ({busy, status} !== {1'b1, st}) begin
            errors++; $display("FAIL r10_status: got busy=%b st=%h expected busy=1 st=%h", busy, status, st);
        end
        get_status();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL r10_busy_clear: got %b expected 0", busy);
        end
    endtask

    task automatic test_read6_two_sectors();
        logic [95:0] c;
        longint unsigned lba, cnt;
        logic [7:0] st;
        bit to;
        clear_obs();
        c = cdb6(8'h00, 8'h00, 8'h05, 8'h02);
        st = model_status(c, lba, cnt);
        fill_expected(lba, cnt);
        send_cmd(c);
        wait_end(80000, to);
        checks++;
        if (to || got_q.size() != 4096 || stream_mismatches(4096) != 0) begin
            errors++; $display("FAIL r6_stream: got %0d bytes expected 4096 matching (timeout=%0d)", got_q.size(), to);
        end
        checks++;
        if (addr_q.size() != 2048 || addr_q[0] !== AW'(IMG_BASE + 5120) ||
            addr_q[2047] !== AW'(IMG_BASE + 7167) || addr_mismatches(lba) != 0) begin
            errors++; $display("FAIL r6_addresses: got %0d reqs, %0d out of order expected 2048,0", addr_q.size(), addr_mismatches(lba));
        end
        checks++;
        if (end_cnt != 1 || status !== st) begin
            errors++; $display("FAIL r6_end_status: got %0d pulses st=%h expected 1 st=%h", end_cnt, status, st);
        end
        get_status();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL r6_busy_clear: got %b expected 0", busy);
        end
    endtask

    task automatic test_reject_cases();
        logic [95:0] dir [6];
        logic [95:0] c;
        longint unsigned lba, cnt;
        logic [7:0] st;
        bit to;
        dir[0] = 96'h12;
        dir[1] = 96'h00;
        dir[2] = cdb10(32'(IMG_SECTORS - 1), 16'd2);
        dir[3] = cdb10(32'hffff_ffff, 16'd1);
        dir[4] = cdb10(32'd5, 16'd0);
        dir[5] = cdb6(8'h00, 8'h0f, 8'ha0, 8'h00);
        for (int it = 0; it < 16; it++) begin
            if (it < 6) begin
                c = dir[it];
            end else begin
                c = cdb10(32'hffff_ffff, 16'd1);
                for (int tries = 0; tries < 200; tries++) begin
                    case ($urandom_range(0, 2))
                        0: c = cdb6(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                        1: c = cdb10(($urandom_range(0, 1) != 0) ? 32'($urandom)
                                                                  : 32'(IMG_SECTORS - $urandom_range(0, 40)),
                                     ($urandom_range(0, 3) == 0) ? 16'hffff : 16'($urandom_range(0, 80)));
                        default: c = {$urandom, $urandom, $urandom};
                    endcase
                    st = model_status(c, lba, cnt);
                    if (cnt == 0) break;
                end
                st = model_status(c, lba, cnt);
                if (cnt != 0) c = cdb10(32'hffff_ffff, 16'd1);
            end
            st = model_status(c, lba, cnt);
            clear_obs();
            send_cmd(c);
            wait_end(50, to);
            checks++;
            if (to || end_cnt != 1 || status !== st) begin
                errors++; $display("FAIL reject_status[%0d] op=%h: got %0d pulses st=%h expected 1 st=%h", it, c[7:0], end_cnt, status, st);
            end
            checks++;
            if (got_q.size() != 0 || addr_q.size() != 0) begin
                errors++; $display("FAIL reject_no_data[%0d]: got %0d bytes %0d reqs expected 0,0", it, got_q.size(), addr_q.size());
            end
            get_status();
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL reject_busy_clear[%0d]: got %b expected 0", it, busy);
            end
        end
    endtask

    task automatic test_abort_and_restart();
        logic [95:0] c;
        longint unsigned lba, cnt;
        logic [7:0] st;
        bit to;
        int n;
        clear_obs();
        ce_mode = 1;
        c = cdb10(32'(IMG_SECTORS - 1), 16'd1);
        st = model_status(c, lba, cnt);
        fill_expected(lba, cnt);
        send_cmd(c);
        wait_bytes(100, 5000, to);
        send_cmd(cdb10(32'd0, 16'd1));      // arrives while busy, must be ignored
        wait_bytes(700, 20000, to);
        ce_mode = 2;
        res = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res = 1'b0;
        checks++;
        if ({status, cd_data, cd_wr, cd_end, img_rd, busy} !== 20'h0 || img_a !== '0) begin
            errors++; $display("FAIL abort_reset_outputs: got st=%h d=%h wr=%b end=%b rd=%b busy=%b a=%h expected all 0",
                               status, cd_data, cd_wr, cd_end, img_rd, busy, img_a);
        end
        n = got_q.size();
        checks++;
        if (to || n < 700 || n > exp_q.size() || stream_mismatches(n) != 0 || min_gap < int'(BYTE_GAP)) begin
            errors++; $display("FAIL abort_stream_before_reset: got %0d bytes gap %0d (timeout=%0d) expected >=700 matching gap>=%0d",
                               n, min_gap, to, BYTE_GAP);
        end
        ce_mode = 0;
        repeat (40) @(negedge clk);
        checks++;
        if (got_q.size() != n || end_cnt != 0 || img_rd !== 1'b0) begin
            errors++; $display("FAIL abort_quiet: got %0d new bytes end=%0d rd=%b expected 0,0,0", got_q.size() - n, end_cnt, img_rd);
        end
        clear_obs();
        c = cdb10(32'd20, 16'd1);
        st = model_status(c, lba, cnt);
        fill_expected(lba, cnt);
        send_cmd(c);
        wait_bytes(16, 2000, to);
        checks++;
        if (to || stream_mismatches(16) != 0 || addr_q[0] !== word_addr(20, 0)) begin
            errors++; $display("FAIL restart_from_byte0: got %0d bytes first=%h expected %h (timeout=%0d)",
                               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00, exp_q[0], to);
        end
    endtask

    initial begin
        res = 1'b1;
        command = '0;
        comm_send = 1'b0;
        stat_get = 1'b0;
        clear_obs();
        test_reset();
        test_read10_single();
        test_read6_two_sectors();
        test_reject_cases();
        test_abort_and_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
